div_seq_16: RTL and testbench

- Iterative 16-bit unsigned restoring divider for the SUBARRAY_MAC datapath.
- Performs the inverse of the MAC accumulate path: scales or normalises accumulated sums by a divisor.
- Produces one quotient bit per cycle using a CLA-based subtractor.
- Uses a valid/ready handshake on both the input and output sides.

---
 rtl/div_seq_16_pkg.sv | 16 +
 rtl/div_seq_16_sub.sv | 50 +++++
 rtl/div_seq_16.sv | 141 ++++++++++++++
 tb/tb_div_seq_16.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_16_pkg.sv
// Shared constants and state encoding for the sequential 16-bit divider.
package div_seq_16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Quotient reported when the divisor is zero
    localparam logic [WIDTH-1:0] DBZ_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_seq_16_sub.sv
// 16-bit subtractor a - b built as a + ~b + 1 on a two-level carry-lookahead adder.
module sub_cla_16
    import div_seq_16_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             cout
);

    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic [3:0]       gg;
    logic [3:0]       gp;
    logic [4:0]       gc;

    // Group generate/propagate, group carries, then bit carries inside each nibble
    always_comb begin
        bn = ~b;
        g  = a & bn;
        p  = a ^ bn;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        c[WIDTH] = gc[4];
        diff     = p ^ c[WIDTH-1:0];
        cout     = c[WIDTH];
    end

endmodule

// File: rtl/div_seq_16.sv
// Iterative 16-bit unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
module div_seq_16
    import div_seq_16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] dvd_q,       dvd_d;
    logic [WIDTH-1:0] dvs_q,       dvs_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quot_q,      quot_d;
    logic [WIDTH-1:0] remo_q,      remo_d;
    logic             dbz_q,       dbz_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_cout;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;

    sub_cla_16 u_sub (
        .a    (r_sh[WIDTH-1:0]),
        .b    (dvs_q),
        .diff (sub_diff),
        .cout (sub_cout)
    );

    // One restoring step: shift in the next dividend bit and keep the difference if it fits.
    // The stored remainder is always below the divisor, so only the shifted value needs 17 bits.
    always_comb begin
        r_sh    = {rem_q, dvd_q[WIDTH-1]};
        q_bit   = r_sh[WIDTH] | sub_cout;
        rem_nxt = q_bit ? sub_diff : r_sh[WIDTH-1:0];
    end

    // Next-state and register updates for IDLE / CALC / DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        remo_d      = remo_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d      = dividend;
                    dvs_d      = divisor;
                    in_ready_d = 1'b0;
                    if (divisor != '0) begin
                        rem_d   = '0;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = CALC;
                    end else begin
                        quot_d      = DBZ_QUOT;
                        remo_d      = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                rem_d = rem_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    quot_d      = {dvd_q[WIDTH-2:0], q_bit};
                    remo_d      = rem_nxt;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            remo_q      <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            remo_q      <= remo_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_16.sv
// Scoreboard bench for div_seq_16: driver pushes a/b, a%b expectations, monitor checks results and latency.
module tb_div_seq_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   or_mode  = 0;
    bit   mon_en   = 1'b0;
    bit   prev_ov  = 1'b0;
    bit   pend_after = 1'b0;

    div_seq_16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, random backpressure, or held off
    always @(negedge clk) begin
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented result against the queue head every cycle it is valid
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ov    = 1'b0;
            pend_after = 1'b0;
        end else if (mon_en) begin
            if (pend_after) begin
                chk("out_valid_drop", 32'(out_valid), 32'd0);
                chk("in_ready_back", 32'(in_ready), 32'd1);
                pend_after = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got q=%0h r=%0h with nothing outstanding", quotient, remainder);
                end else begin
                    e = sb[0];
                    if (!prev_ov)
                        chk($sformatf("latency %0h/%0h", e.a, e.b), 32'(cyc - e.acc), e.z ? 32'd1 : 32'd17);
                    chk($sformatf("quotient %0h/%0h", e.a, e.b), 32'(quotient), 32'(e.q));
                    chk($sformatf("remainder %0h/%0h", e.a, e.b), 32'(remainder), 32'(e.r));
                    chk($sformatf("div_by_zero %0h/%0h", e.a, e.b), 32'(div_by_zero), 32'(e.z));
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        pend_after = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    // One cycle of idle driving; junk is offered only while the divider is busy
    task automatic junk_cycle();
        @(negedge clk);
        if (in_ready) begin
            in_valid = 1'b0;
        end else begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
        end
    endtask

    // Present one operand pair and push its reference result when it will be accepted
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        exp_t x;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%0b required 1 for %0h/%0h", in_ready, a, b);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        x.a   = a;
        x.b   = b;
        x.z   = (b == 16'd0);
        x.q   = x.z ? 16'hFFFF : a / b;
        x.r   = x.z ? a : a % b;
        x.acc = cyc;
        sb.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            junk_cycle();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: outstanding=%0d required 0", sb.size());
            sb.delete();
        end
        junk_cycle();
        junk_cycle();
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          n;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed corner cases
        or_mode = 0;
        issue(16'd100, 16'd7);
        issue(16'hFFFF, 16'h0001);
        issue(16'hFFFF, 16'h8001);
        issue(16'h8000, 16'hFFFF);
        issue(16'd5, 16'd0);
        issue(16'd0, 16'd1);
        issue(16'd3, 16'd9);
        drain();

        // Backpressure: hold the result for 5 cycles with junk operands offered
        or_mode = 2;
        issue(16'd1234, 16'd56);
        n = 0;
        while (!out_valid && n < 40) begin
            junk_cycle();
            n++;
        end
        repeat (5) junk_cycle();
        or_mode = 0;
        drain();

        // Reset in the middle of a division
        issue(16'hABCD, 16'h0003);
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd1);
        chk("midreset_quotient", 32'(quotient), 32'd0);
        chk("midreset_remainder", 32'(remainder), 32'd0);
        chk("midreset_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd9, 16'd3);
        drain();

        // Random regression with random backpressure
        or_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            issue(a, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
